// File: rtl/npu_cfg_pkg.sv
// Shared sizing, pass-state encoding and read-only source chunk contents
// for the compute cluster memory.
package npu_cfg_pkg;

   localparam int BUS_SIZE         = 8;
   localparam int WR_DAT_CYC_NUM   = 4;
   localparam int SRAM_IFM_NUM     = 64;
   localparam int SRAM_FILTER_NUM  = 64;
   localparam int COMPUTE_UNIT_NUM = 4;
   localparam int PREFIX_SUM_SIZE  = 8;
   localparam int RD_DAT_CYC_NUM   =
      WR_DAT_CYC_NUM * BUS_SIZE / PREFIX_SUM_SIZE;
   localparam int OUTPUT_BUF_NUM   = 16;
   localparam int ACC_W            = 32;
   localparam int OUTPUT_BUF_SIZE  = OUTPUT_BUF_NUM * ACC_W;

   localparam int ELEM_W      = 8;
   localparam int CHUNK_ELEMS = WR_DAT_CYC_NUM * BUS_SIZE;
   localparam int CHUNK_W     = CHUNK_ELEMS * ELEM_W;
   localparam int WORD_W      = BUS_SIZE * ELEM_W;
   localparam int VEC_W       = PREFIX_SUM_SIZE * ELEM_W;
   localparam int WR_CNT_W    = $clog2(WR_DAT_CYC_NUM);
   localparam int IFM_ADR_W   = $clog2(SRAM_IFM_NUM);
   localparam int FIL_ADR_W   = $clog2(SRAM_FILTER_NUM);
   localparam int CU_SEL_W    = $clog2(COMPUTE_UNIT_NUM);
   localparam int RD_CNT_W    = $clog2(RD_DAT_CYC_NUM);
   localparam int ACC_SEL_W   = $clog2(OUTPUT_BUF_NUM);

   typedef enum logic {
      ST_IDLE,
      ST_RUN
   } pass_st_e;

   function automatic logic [WORD_W-1:0] ifm_src_word(
      input logic [IFM_ADR_W-1:0] c,
      input logic [WR_CNT_W-1:0]  w
   );
      logic [WORD_W-1:0] v;
      v = '0;
      for (int l = 0; l < BUS_SIZE; l++)
         v[l*ELEM_W +: ELEM_W] =
            ELEM_W'((int'(c) + int'(w) * BUS_SIZE + l) & 7);
      return v;
   endfunction

   function automatic logic [WORD_W-1:0] fil_src_word(
      input logic [FIL_ADR_W-1:0] c
   );
      logic [WORD_W-1:0] v;
      v = '0;
      for (int l = 0; l < BUS_SIZE; l++)
         v[l*ELEM_W +: ELEM_W] = ELEM_W'((int'(c) & 3) + 1);
      return v;
   endfunction

endpackage

// File: rtl/compute_cluster_mem_cu.sv
// One compute unit: double-buffered filter chunk, signed dot-product MAC
// and a bank of accumulators that only reset can clear.
module compute_unit
   import npu_cfg_pkg::*;
(
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       i_wr_en,
   input  logic [WR_CNT_W-1:0]        i_wr_count,
   input  logic                       i_wr_sel,
   input  logic [WORD_W-1:0]          i_wr_word,
   input  logic                       i_rd_sel,
   input  logic [RD_CNT_W-1:0]        i_step,
   input  logic [VEC_W-1:0]           i_ifm_vec,
   input  logic                       i_mac_en,
   input  logic [ACC_SEL_W-1:0]       i_acc_sel,
   output logic [OUTPUT_BUF_SIZE-1:0] o_acc
);

   logic [CHUNK_W-1:0] r_fil [2];
   logic [ACC_W-1:0]   r_acc [OUTPUT_BUF_NUM];
   logic [VEC_W-1:0]   w_fil_vec;
   logic [ACC_W-1:0]   w_dot;

   always_comb begin
      logic signed [2*ELEM_W-1:0] w_prod;
      w_dot     = '0;
      w_prod    = '0;
      w_fil_vec = r_fil[i_rd_sel][int'(i_step)*VEC_W +: VEC_W];
      for (int i = 0; i < PREFIX_SUM_SIZE; i++) begin
         w_prod = $signed(i_ifm_vec[i*ELEM_W +: ELEM_W]) *
                  $signed(w_fil_vec[i*ELEM_W +: ELEM_W]);
         w_dot  = w_dot +
                  {{(ACC_W-2*ELEM_W){w_prod[2*ELEM_W-1]}}, w_prod};
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_fil <= '{default: '0};
         r_acc <= '{default: '0};
      end else begin
         if (i_wr_en)
            r_fil[i_wr_sel][int'(i_wr_count)*WORD_W +: WORD_W]
               <= i_wr_word;
         if (i_mac_en)
            r_acc[i_acc_sel] <= r_acc[i_acc_sel] + w_dot;
      end
   end

   always_comb begin
      o_acc = '0;
      for (int b = 0; b < OUTPUT_BUF_NUM; b++)
         o_acc[b*ACC_W +: ACC_W] = r_acc[b];
   end

endmodule

// File: rtl/compute_cluster_mem.sv
// Compute cluster memory: shared IFM double buffer and pass sequencer
// feeding the compute units. CHANNEL_PADDING_EN adds explicit pass control.
module compute_cluster_mem
   import npu_cfg_pkg::*;
(
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        ifm_chunk_wr_valid_i,
   input  logic [WR_CNT_W-1:0]         ifm_chunk_wr_count_i,
   input  logic                        ifm_chunk_wr_sel_i,
   input  logic                        ifm_chunk_rd_sel_i,
   input  logic [IFM_ADR_W-1:0]        ifm_sram_rd_count_i,
   input  logic                        fil_chunk_wr_valid_i,
   input  logic [WR_CNT_W-1:0]         fil_chunk_wr_count_i,
   input  logic                        fil_chunk_wr_sel_i,
   input  logic                        fil_chunk_rd_sel_i,
   input  logic [FIL_ADR_W-1:0]        fil_sram_rd_count_i,
   input  logic [COMPUTE_UNIT_NUM-1:0] fil_chunk_cu_wr_sel_i,
   input  logic                        run_valid_i,
   input  logic [CU_SEL_W-1:0]         com_unit_out_buf_sel_i,
`ifdef CHANNEL_PADDING_EN
   input  logic                        total_chunk_start_i,
   input  logic [RD_CNT_W-1:0]         rd_fil_sparsemap_last_i,
   input  logic [ACC_SEL_W-1:0]        acc_buf_sel_i,
   output logic                        total_chunk_end_o,
`endif
   output logic [OUTPUT_BUF_SIZE-1:0]  out_buf_dat_o
);

   logic [CHUNK_W-1:0]         r_ifm [2];
   pass_st_e                   r_state, w_state_nxt;
   logic [RD_CNT_W-1:0]        r_step, w_step_nxt;
   logic [RD_CNT_W-1:0]        r_last, w_last_nxt;
   logic [ACC_SEL_W-1:0]       r_acc_sel, w_acc_sel_nxt;
   logic                       w_busy, w_step_en, w_end;
   logic                       w_start, w_start_req;
   logic [RD_CNT_W-1:0]        w_last_in;
   logic [ACC_SEL_W-1:0]       w_acc_in;
   logic [VEC_W-1:0]           w_ifm_vec;
   logic [WORD_W-1:0]          w_fil_word;
   logic [OUTPUT_BUF_SIZE-1:0] w_cu_acc [COMPUTE_UNIT_NUM];

`ifdef CHANNEL_PADDING_EN
   assign w_start_req       = total_chunk_start_i;
   assign w_last_in         = rd_fil_sparsemap_last_i;
   assign w_acc_in          = acc_buf_sel_i;
   assign total_chunk_end_o = w_end;
`else
   logic r_run_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_run_q <= 1'b0;
      else       r_run_q <= run_valid_i;
   end

   // Rising run edge starts from idle; a running pass always relaunches.
   assign w_start_req = w_busy | ~r_run_q;
   assign w_last_in   = RD_CNT_W'(RD_DAT_CYC_NUM - 1);
   assign w_acc_in    = '0;
`endif

   assign w_busy    = (r_state == ST_RUN);
   assign w_step_en = w_busy & run_valid_i;
   assign w_end     = w_step_en & (r_step == r_last);
   assign w_start   = run_valid_i & w_start_req & (~w_busy | w_end);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state   <= ST_IDLE;
         r_step    <= '0;
         r_last    <= '0;
         r_acc_sel <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_step    <= w_step_nxt;
         r_last    <= w_last_nxt;
         r_acc_sel <= w_acc_sel_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_step_nxt    = r_step;
      w_last_nxt    = r_last;
      w_acc_sel_nxt = r_acc_sel;
      if (w_start) begin
         w_state_nxt   = ST_RUN;
         w_step_nxt    = '0;
         w_last_nxt    = w_last_in;
         w_acc_sel_nxt = w_acc_in;
      end else if (w_end) begin
         w_state_nxt   = ST_IDLE;
      end else if (w_step_en) begin
         w_step_nxt    = r_step + RD_CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         r_ifm <= '{default: '0};
      else if (ifm_chunk_wr_valid_i)
         r_ifm[ifm_chunk_wr_sel_i]
              [int'(ifm_chunk_wr_count_i)*WORD_W +: WORD_W]
            <= ifm_src_word(ifm_sram_rd_count_i,
                            ifm_chunk_wr_count_i);
   end

   assign w_ifm_vec  =
      r_ifm[ifm_chunk_rd_sel_i][int'(r_step)*VEC_W +: VEC_W];
   assign w_fil_word = fil_src_word(fil_sram_rd_count_i);

   for (genvar u = 0; u < COMPUTE_UNIT_NUM; u++) begin : g_cu
      compute_unit u_cu (
         .clk_i      (clk_i),
         .rst_i      (rst_i),
         .i_wr_en    (fil_chunk_wr_valid_i & fil_chunk_cu_wr_sel_i[u]),
         .i_wr_count (fil_chunk_wr_count_i),
         .i_wr_sel   (fil_chunk_wr_sel_i),
         .i_wr_word  (w_fil_word),
         .i_rd_sel   (fil_chunk_rd_sel_i),
         .i_step     (r_step),
         .i_ifm_vec  (w_ifm_vec),
         .i_mac_en   (w_step_en),
         .i_acc_sel  (r_acc_sel),
         .o_acc      (w_cu_acc[u])
      );
   end

   assign out_buf_dat_o = w_cu_acc[com_unit_out_buf_sel_i];

endmodule

// File: tb/tb_compute_cluster_mem.sv
// Self-checking bench for compute_cluster_mem: directed table plus random
// traffic against an array-based reference model.
module tb_compute_cluster_mem;
   import npu_cfg_pkg::*;

   logic                        clk_i = 1'b0;
   logic                        rst_i;
   logic                        ifm_chunk_wr_valid_i;
   logic [WR_CNT_W-1:0]         ifm_chunk_wr_count_i;
   logic                        ifm_chunk_wr_sel_i;
   logic                        ifm_chunk_rd_sel_i;
   logic [IFM_ADR_W-1:0]        ifm_sram_rd_count_i;
   logic                        fil_chunk_wr_valid_i;
   logic [WR_CNT_W-1:0]         fil_chunk_wr_count_i;
   logic                        fil_chunk_wr_sel_i;
   logic                        fil_chunk_rd_sel_i;
   logic [FIL_ADR_W-1:0]        fil_sram_rd_count_i;
   logic [COMPUTE_UNIT_NUM-1:0] fil_chunk_cu_wr_sel_i;
   logic                        run_valid_i;
   logic [CU_SEL_W-1:0]         com_unit_out_buf_sel_i;
   logic [OUTPUT_BUF_SIZE-1:0]  out_buf_dat_o;
`ifdef CHANNEL_PADDING_EN
   logic                        total_chunk_start_i;
   logic [RD_CNT_W-1:0]         rd_fil_sparsemap_last_i;
   logic [ACC_SEL_W-1:0]        acc_buf_sel_i;
   logic                        total_chunk_end_o;
   logic                        seen_end;
`endif

   compute_cluster_mem dut (
      .clk_i                  (clk_i),
      .rst_i                  (rst_i),
      .ifm_chunk_wr_valid_i   (ifm_chunk_wr_valid_i),
      .ifm_chunk_wr_count_i   (ifm_chunk_wr_count_i),
      .ifm_chunk_wr_sel_i     (ifm_chunk_wr_sel_i),
      .ifm_chunk_rd_sel_i     (ifm_chunk_rd_sel_i),
      .ifm_sram_rd_count_i    (ifm_sram_rd_count_i),
      .fil_chunk_wr_valid_i   (fil_chunk_wr_valid_i),
      .fil_chunk_wr_count_i   (fil_chunk_wr_count_i),
      .fil_chunk_wr_sel_i     (fil_chunk_wr_sel_i),
      .fil_chunk_rd_sel_i     (fil_chunk_rd_sel_i),
      .fil_sram_rd_count_i    (fil_sram_rd_count_i),
      .fil_chunk_cu_wr_sel_i  (fil_chunk_cu_wr_sel_i),
      .run_valid_i            (run_valid_i),
      .com_unit_out_buf_sel_i (com_unit_out_buf_sel_i),
`ifdef CHANNEL_PADDING_EN
      .total_chunk_start_i    (total_chunk_start_i),
      .rd_fil_sparsemap_last_i(rd_fil_sparsemap_last_i),
      .acc_buf_sel_i          (acc_buf_sel_i),
      .total_chunk_end_o      (total_chunk_end_o),
`endif
      .out_buf_dat_o          (out_buf_dat_o)
   );

   always #5 clk_i = ~clk_i;

   int n_err = 0;
   int n_chk = 0;

   // reference model state
   int               m_ifm [2][CHUNK_ELEMS];
   int               m_fil [COMPUTE_UNIT_NUM][2][CHUNK_ELEMS];
   logic [ACC_W-1:0] m_acc [COMPUTE_UNIT_NUM][OUTPUT_BUF_NUM];
   bit               m_busy;
   bit               m_prev_run;
   int               m_k, m_last, m_buf;
   bit               d_started;

   typedef struct {
      int ifm_c;
      int fil_c;
      int mask;
      int acc;
      int ua;
      int ea;
      int ub;
      int eb;
   } vec_t;

`ifdef CHANNEL_PADDING_EN
   localparam int B2 = 5, B3 = 9;
   localparam int E3A = 224, E3B = 112, E4 = 336;
   localparam int BB_BUF = 1, BB_EXP = 672;
`else
   localparam int B2 = 0, B3 = 0;
   localparam int E3A = 448, E3B = 336, E4 = 672;
   localparam int BB_BUF = 0, BB_EXP = 1344;
`endif

   function automatic void chk(string nm,
                               logic [OUTPUT_BUF_SIZE-1:0] act,
                               logic [OUTPUT_BUF_SIZE-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endfunction

   function automatic void model_reset();
      for (int b = 0; b < 2; b++)
         for (int e = 0; e < CHUNK_ELEMS; e++) begin
            m_ifm[b][e] = 0;
            for (int u = 0; u < COMPUTE_UNIT_NUM; u++)
               m_fil[u][b][e] = 0;
         end
      for (int u = 0; u < COMPUTE_UNIT_NUM; u++)
         for (int b = 0; b < OUTPUT_BUF_NUM; b++)
            m_acc[u][b] = '0;
      m_busy     = 0;
      m_prev_run = 0;
      m_k        = 0;
      m_last     = 0;
      m_buf      = 0;
   endfunction

   function automatic int dot(int u, int k);
      int s = 0;
      for (int i = 0; i < PREFIX_SUM_SIZE; i++)
         s += m_ifm[ifm_chunk_rd_sel_i][k*PREFIX_SUM_SIZE+i] *
              m_fil[u][fil_chunk_rd_sel_i][k*PREFIX_SUM_SIZE+i];
      return s;
   endfunction

   task automatic check_cycle();
      logic [OUTPUT_BUF_SIZE-1:0] eb;
      bit step, e_end, start;
      if (rst_i) begin
         model_reset();
         chk("rst_out_buf", out_buf_dat_o, '0);
`ifdef CHANNEL_PADDING_EN
         chk("rst_end", total_chunk_end_o, 0);
`endif
         return;
      end
      step  = m_busy && run_valid_i;
      e_end = step && (m_k == m_last);
      eb    = '0;
      for (int b = 0; b < OUTPUT_BUF_NUM; b++)
         eb[b*ACC_W +: ACC_W] = m_acc[com_unit_out_buf_sel_i][b];
      chk("out_buf", out_buf_dat_o, eb);
`ifdef CHANNEL_PADDING_EN
      chk("end", total_chunk_end_o, e_end);
      start = run_valid_i && total_chunk_start_i && (!m_busy || e_end);
`else
      start = run_valid_i && ((!m_busy && !m_prev_run) || e_end);
`endif
      if (step)
         for (int u = 0; u < COMPUTE_UNIT_NUM; u++)
            m_acc[u][m_buf] += ACC_W'(dot(u, m_k));
      if (start) begin
         m_busy = 1;
         m_k    = 0;
`ifdef CHANNEL_PADDING_EN
         m_last = int'(rd_fil_sparsemap_last_i);
         m_buf  = int'(acc_buf_sel_i);
`else
         m_last = RD_DAT_CYC_NUM - 1;
         m_buf  = 0;
`endif
      end else if (e_end) begin
         m_busy = 0;
      end else if (step) begin
         m_k++;
      end
      if (ifm_chunk_wr_valid_i)
         for (int l = 0; l < BUS_SIZE; l++)
            m_ifm[ifm_chunk_wr_sel_i]
                 [int'(ifm_chunk_wr_count_i)*BUS_SIZE+l] =
               (int'(ifm_sram_rd_count_i) +
                int'(ifm_chunk_wr_count_i)*BUS_SIZE + l) & 7;
      if (fil_chunk_wr_valid_i)
         for (int u = 0; u < COMPUTE_UNIT_NUM; u++)
            if (fil_chunk_cu_wr_sel_i[u])
               for (int l = 0; l < BUS_SIZE; l++)
                  m_fil[u][fil_chunk_wr_sel_i]
                       [int'(fil_chunk_wr_count_i)*BUS_SIZE+l] =
                     (int'(fil_sram_rd_count_i) & 3) + 1;
      m_prev_run = run_valid_i;
   endtask

   task automatic cycle();
      @(negedge clk_i);
`ifdef CHANNEL_PADDING_EN
      seen_end = total_chunk_end_o;
`endif
      check_cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      ifm_chunk_wr_valid_i   = 0;
      ifm_chunk_wr_count_i   = '0;
      ifm_chunk_wr_sel_i     = 0;
      ifm_chunk_rd_sel_i     = 0;
      ifm_sram_rd_count_i    = '0;
      fil_chunk_wr_valid_i   = 0;
      fil_chunk_wr_count_i   = '0;
      fil_chunk_wr_sel_i     = 0;
      fil_chunk_rd_sel_i     = 0;
      fil_sram_rd_count_i    = '0;
      fil_chunk_cu_wr_sel_i  = '0;
      run_valid_i            = 0;
      com_unit_out_buf_sel_i = '0;
`ifdef CHANNEL_PADDING_EN
      total_chunk_start_i     = 0;
      rd_fil_sparsemap_last_i = '0;
      acc_buf_sel_i           = '0;
`endif
   endtask

   task automatic load(int ifm_c, int fil_c, int mask);
      for (int w = 0; w < WR_DAT_CYC_NUM; w++) begin
         ifm_chunk_wr_valid_i  = 1;
         ifm_chunk_wr_count_i  = WR_CNT_W'(w);
         ifm_sram_rd_count_i   = IFM_ADR_W'(ifm_c);
         fil_chunk_wr_valid_i  = (mask != 0);
         fil_chunk_wr_count_i  = WR_CNT_W'(w);
         fil_sram_rd_count_i   = FIL_ADR_W'(fil_c);
         fil_chunk_cu_wr_sel_i = COMPUTE_UNIT_NUM'(mask);
         cycle();
      end
      ifm_chunk_wr_valid_i  = 0;
      fil_chunk_wr_valid_i  = 0;
      fil_chunk_cu_wr_sel_i = '0;
   endtask

   task automatic run_pass(int acc);
`ifdef CHANNEL_PADDING_EN
      int lat;
      lat = -1;
      run_valid_i             = 1;
      total_chunk_start_i     = 1;
      rd_fil_sparsemap_last_i = RD_CNT_W'(3);
      acc_buf_sel_i           = ACC_SEL_W'(acc);
      cycle();
      total_chunk_start_i = 0;
      for (int i = 1; i <= 8 && lat < 0; i++) begin
         cycle();
         if (seen_end) lat = i;
      end
      chk("pass_latency", lat, 4);
`else
      run_valid_i = 1;
      if (!d_started) begin
         cycle();
         d_started = 1;
      end
      repeat (RD_DAT_CYC_NUM) cycle();
`endif
      run_valid_i = 0;
   endtask

   task automatic chk_buf(string nm, int u, int b, int exp);
      com_unit_out_buf_sel_i = CU_SEL_W'(u);
      #1;
      chk(nm, out_buf_dat_o[b*ACC_W +: ACC_W], exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t tbl[4];
      tbl[0] = '{0, 0, 15, 0,  0, 112, 3, 112};
      tbl[1] = '{0, 0, 0,  0,  0, 224, 1, 224};
      tbl[2] = '{0, 1, 4,  B2, 2, E3A, 0, E3B};
      tbl[3] = '{5, 2, 15, B3, 1, E4,  3, E4};

      model_reset();
      d_started = 0;
      idle_inputs();
      rst_i = 1;
      cycle();
      cycle();
      rst_i = 0;
      chk_buf("reset_buf0", 0, 0, 0);

      for (int i = 0; i < 4; i++) begin
         load(tbl[i].ifm_c, tbl[i].fil_c, tbl[i].mask);
         run_pass(tbl[i].acc);
         chk_buf($sformatf("tbl%0d_a", i), tbl[i].ua, tbl[i].acc,
                 tbl[i].ea);
         chk_buf($sformatf("tbl%0d_b", i), tbl[i].ub, tbl[i].acc,
                 tbl[i].eb);
      end

      // back-to-back passes, one start while busy
      begin
         int ends[$];
`ifdef CHANNEL_PADDING_EN
         rd_fil_sparsemap_last_i = RD_CNT_W'(3);
         acc_buf_sel_i           = ACC_SEL_W'(BB_BUF);
`endif
         for (int i = 0; i < 12; i++) begin
`ifdef CHANNEL_PADDING_EN
            run_valid_i         = 1;
            total_chunk_start_i = (i == 0 || i == 2 || i == 4);
            cycle();
            if (seen_end) ends.push_back(i);
`else
            run_valid_i = (i < 8);
            cycle();
`endif
         end
`ifdef CHANNEL_PADDING_EN
         total_chunk_start_i = 0;
         chk("b2b_count", ends.size(), 2);
         chk("b2b_first", ends.size() > 0 ? ends[0] : -1, 4);
         chk("b2b_gap", ends.size() > 1 ? ends[1] - ends[0] : -1, 4);
`endif
         run_valid_i = 0;
         chk_buf("b2b_acc", 0, BB_BUF, BB_EXP);
      end

      // reset in the middle of a pass
      begin
         int n_end = 0;
         run_valid_i = 1;
`ifdef CHANNEL_PADDING_EN
         total_chunk_start_i = 1;
         acc_buf_sel_i       = ACC_SEL_W'(0);
         cycle();
         total_chunk_start_i = 0;
`endif
         cycle();
         cycle();
         run_valid_i = 0;
         rst_i = 1;
         cycle();
         cycle();
         rst_i = 0;
         d_started = 0;
         for (int i = 0; i < 6; i++) begin
            cycle();
`ifdef CHANNEL_PADDING_EN
            if (seen_end) n_end++;
`endif
         end
         chk("abort_no_end", n_end, 0);
         chk_buf("abort_acc0", 0, 0, 0);
         chk_buf("abort_acc5", 2, 5, 0);
      end

      for (int c = 0; c < 800; c++) begin
         ifm_chunk_wr_valid_i   = 1'($urandom_range(0, 1));
         ifm_chunk_wr_count_i   = WR_CNT_W'($urandom);
         ifm_chunk_wr_sel_i     = 1'($urandom);
         ifm_chunk_rd_sel_i     = 1'($urandom);
         ifm_sram_rd_count_i    = IFM_ADR_W'($urandom);
         fil_chunk_wr_valid_i   = 1'($urandom_range(0, 1));
         fil_chunk_wr_count_i   = WR_CNT_W'($urandom);
         fil_chunk_wr_sel_i     = 1'($urandom);
         fil_chunk_rd_sel_i     = 1'($urandom);
         fil_sram_rd_count_i    = FIL_ADR_W'($urandom);
         fil_chunk_cu_wr_sel_i  = COMPUTE_UNIT_NUM'($urandom);
         run_valid_i            = ($urandom_range(0, 9) < 7);
         com_unit_out_buf_sel_i = CU_SEL_W'($urandom);
`ifdef CHANNEL_PADDING_EN
         total_chunk_start_i     = ($urandom_range(0, 3) == 0);
         rd_fil_sparsemap_last_i = RD_CNT_W'($urandom);
         acc_buf_sel_i           = ACC_SEL_W'($urandom);
`endif
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
